// File: rtl/uart_pkg.sv
// UART shared constants: baud selection codes and phase-increment helper.
// No ports; imported by baud_gen.
package uart_pkg;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  localparam int NUM_RATES = 5;

  // round(16 * baud * 2^acc_w / clk_freq)
  function automatic longint unsigned baud_inc(
    input longint unsigned clk_freq,
    input longint unsigned baud,
    input int              acc_w
  );
    longint unsigned num;
    num = (64'd16 * baud) << acc_w;
    return (num + (clk_freq >> 1)) / clk_freq;
  endfunction

endpackage

// File: rtl/baud_gen.sv
// Fractional baud generator: 16x os_tick and 1x baud_tick from clk.
// Ports: clk, rst, sel[2:0], busy -> os_tick, baud_tick, active_sel, rate_changed.
module baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 12000000,
  parameter int ACC_W    = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sel,
  input  logic       busy,
  output logic       os_tick,
  output logic       baud_tick,
  output logic [2:0] active_sel,
  output logic       rate_changed
);

  localparam longint unsigned CF = longint'(CLK_FREQ);

  localparam logic [ACC_W-1:0] INC0 =
    ACC_W'(baud_inc(CF, 64'd9600, ACC_W));
  localparam logic [ACC_W-1:0] INC1 =
    ACC_W'(baud_inc(CF, 64'd19200, ACC_W));
  localparam logic [ACC_W-1:0] INC2 =
    ACC_W'(baud_inc(CF, 64'd38400, ACC_W));
  localparam logic [ACC_W-1:0] INC3 =
    ACC_W'(baud_inc(CF, 64'd57600, ACC_W));
  localparam logic [ACC_W-1:0] INC4 =
    ACC_W'(baud_inc(CF, 64'd115200, ACC_W));

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       div_q, div_d;
  logic             os_q, os_d;
  logic             bt_q, bt_d;
  logic [2:0]       act_q, act_d;
  logic             rc_q, rc_d;

  logic [2:0]       sel_n;
  logic [ACC_W-1:0] inc;
  logic [ACC_W:0]   sum;
  logic             carry;

  // Unsupported codes fall back to 9600 before comparing.
  assign sel_n = (sel > BAUD_115200) ? BAUD_9600 : sel;

  always_comb begin
    case (act_q)
      BAUD_19200:  inc = INC1;
      BAUD_38400:  inc = INC2;
      BAUD_57600:  inc = INC3;
      BAUD_115200: inc = INC4;
      default:     inc = INC0;
    endcase
  end

  assign sum   = {1'b0, acc_q} + {1'b0, inc};
  assign carry = sum[ACC_W];

  always_comb begin
    acc_d = sum[ACC_W-1:0];
    div_d = div_q;
    os_d  = carry;
    bt_d  = 1'b0;
    act_d = act_q;
    rc_d  = 1'b0;
    if (!busy && (sel_n != act_q)) begin
      // Restart phase so the new rate begins cleanly.
      acc_d = '0;
      div_d = '0;
      os_d  = 1'b0;
      act_d = sel_n;
      rc_d  = 1'b1;
    end else if (carry) begin
      div_d = div_q + 4'd1;
      bt_d  = (div_q == 4'd15);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      div_q <= '0;
      os_q  <= 1'b0;
      bt_q  <= 1'b0;
      act_q <= BAUD_9600;
      rc_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      div_q <= div_d;
      os_q  <= os_d;
      bt_q  <= bt_d;
      act_q <= act_d;
      rc_q  <= rc_d;
    end
  end

  assign os_tick      = os_q;
  assign baud_tick    = bt_q;
  assign active_sel   = act_q;
  assign rate_changed = rc_q;

endmodule

// File: tb/tb_baud_gen.sv
// Directed bench for baud_gen: tick counts, gaps, rate changes.
// Vectors run back to back, so each row continues from prior state.
module tb_baud_gen;

  logic       clk;
  logic       rst;
  logic [2:0] sel;
  logic       busy;
  logic       os_tick;
  logic       baud_tick;
  logic [2:0] active_sel;
  logic       rate_changed;

  baud_gen dut (
    .clk          (clk),
    .rst          (rst),
    .sel          (sel),
    .busy         (busy),
    .os_tick      (os_tick),
    .baud_tick    (baud_tick),
    .active_sel   (active_sel),
    .rate_changed (rate_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       r;
    logic [2:0] s;
    logic       b;
    int         n;
    int         e_os;
    int         e_bt;
    int         e_rc;
    int         e_act;
    int         e_gmin;
    int         e_gmax;
  } vec_t;

  vec_t vecs[$];

  int passed = 0;
  int total  = 0;

  int c_os, c_bt, c_rc, gmin, gmax;
  int os_at[$];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic run(input logic r, input logic [2:0] s,
                     input logic b, input int n);
    int last;
    rst  = r;
    sel  = s;
    busy = b;
    c_os = 0;
    c_bt = 0;
    c_rc = 0;
    gmin = 1000000;
    gmax = 0;
    last = -1;
    os_at.delete();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (os_tick) begin
        if (last >= 0) begin
          if (i - last < gmin) gmin = i - last;
          if (i - last > gmax) gmax = i - last;
        end
        last = i;
        c_os++;
        os_at.push_back(i + 1);
      end
      if (baud_tick) c_bt++;
      if (rate_changed) c_rc++;
      if (baud_tick && !os_tick) c_bt += 1000;
    end
  endtask

  initial begin
    rst  = 1'b1;
    sel  = 3'd0;
    busy = 1'b0;

    //           name        r s b n     os  bt rc act gmin gmax
    vecs.push_back('{"reset",     1,0,0,3,    0,  0, 0, 0, 0, 0});
    vecs.push_back('{"pre79",     0,0,0,78,   0,  0, 0, 0, 0, 0});
    vecs.push_back('{"edge79",    0,0,0,1,    1,  0, 0, 0, 0, 0});
    vecs.push_back('{"run9600",   0,0,0,19921,254,15,0, 0, 78,79});
    vecs.push_back('{"to115k",    0,4,0,1,    0,  0, 1, 4, 0, 0});
    vecs.push_back('{"run115k",   0,4,0,1667, 256,16,0, 4, 6, 7});
    vecs.push_back('{"back9600",  0,0,0,1,    0,  0, 1, 0, 0, 0});
    vecs.push_back('{"busy_hold", 0,3,1,79,   1,  0, 0, 0, 0, 0});
    vecs.push_back('{"busy_drop", 0,3,0,1,    0,  0, 1, 3, 0, 0});
    vecs.push_back('{"run57k",    0,3,0,1302, 99, 6, 0, 3, 13,14});
    vecs.push_back('{"mid_rst",   1,3,0,1,    0,  0, 0, 0, 0, 0});
    vecs.push_back('{"rst_pre79", 0,0,0,78,   0,  0, 0, 0, 0, 0});
    vecs.push_back('{"rst_79",    0,0,0,1,    1,  0, 0, 0, 0, 0});
    vecs.push_back('{"sel6",      0,6,0,5,    0,  0, 0, 0, 0, 0});
    vecs.push_back('{"sel2",      0,2,0,1,    0,  0, 1, 2, 0, 0});
    vecs.push_back('{"sel7",      0,7,0,1,    0,  0, 1, 0, 0, 0});
    vecs.push_back('{"sel0_same", 0,0,0,1,    0,  0, 0, 0, 0, 0});

    foreach (vecs[k]) begin
      run(vecs[k].r, vecs[k].s, vecs[k].b, vecs[k].n);
      check({vecs[k].name, ".os"}, c_os, vecs[k].e_os);
      check({vecs[k].name, ".baud"}, c_bt, vecs[k].e_bt);
      check({vecs[k].name, ".rc"}, c_rc, vecs[k].e_rc);
      check({vecs[k].name, ".act"}, int'(active_sel),
            vecs[k].e_act);
      if (vecs[k].e_gmax != 0) begin
        check({vecs[k].name, ".gmin"}, gmin, vecs[k].e_gmin);
        check({vecs[k].name, ".gmax"}, gmax, vecs[k].e_gmax);
      end
    end

    // Reset state: all outputs zero while rst is held.
    run(1'b1, 3'd2, 1'b0, 2);
    check("rst.os", int'(os_tick), 0);
    check("rst.bt", int'(baud_tick), 0);
    check("rst.rc", int'(rate_changed), 0);
    check("rst.act", int'(active_sel), 0);

    // busy held while sel glitches 0->2->0: timing must
    // match an unperturbed 9600 run (edges 79, 157, 235).
    begin
      int ed[$];
      int rcs;
      run(1'b0, 3'd0, 1'b1, 60);
      ed = os_at;
      rcs = c_rc;
      run(1'b0, 3'd2, 1'b1, 40);
      foreach (os_at[j]) ed.push_back(os_at[j] + 60);
      rcs += c_rc;
      run(1'b0, 3'd0, 1'b1, 140);
      foreach (os_at[j]) ed.push_back(os_at[j] + 100);
      rcs += c_rc;
      check("glitch.rc", rcs, 0);
      check("glitch.count", ed.size(), 3);
      check("glitch.e1", (ed.size() > 0) ? ed[0] : -1, 79);
      check("glitch.e2", (ed.size() > 1) ? ed[1] : -1, 157);
      check("glitch.e3", (ed.size() > 2) ? ed[2] : -1, 235);
      check("glitch.act", int'(active_sel), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/baud_gen.md
Name: baud_gen

Overview:
- Decodes the 3-bit baud selection code into the clock-enable ticks that drive the UART datapath.
- Produces a 16x oversample tick for the receiver and a 1x bit tick for the transmitter.
- Uses a fractional phase accumulator so every supported rate stays within 0.01% of nominal from the 12 MHz board clock.
- Rate changes are deferred while a frame is in flight.

Parameters:
- CLK_FREQ, 12000000, system clock frequency in Hz.
- ACC_W, 24, phase accumulator width in bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- sel  in  3  requested baud code: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200.
- busy  in  1  high while the TX or RX datapath is mid-frame; defers rate changes.
- os_tick  out  1  one-cycle pulse at 16x the active baud rate.
- baud_tick  out  1  one-cycle pulse at 1x the active baud rate, coincident with every 16th os_tick.
- active_sel  out  3  code currently in effect.
- rate_changed  out  1  one-cycle pulse when a new code takes effect.

Behaviour:
- Single clock domain. Reset is synchronous, active-high, and has priority over all other logic.
- Reset values: acc=0, div=0, os_tick=0, baud_tick=0, active_sel=0 (9600), rate_changed=0.
- Increment per code, INC = round(16*baud*2^ACC_W/CLK_FREQ), computed as constants. Defaults: 214748, 429497, 858993, 1288490, 2576980.
- Codes 5, 6 and 7 are treated as code 0 (9600). This normalization is applied before the comparison with active_sel.
- Change condition, checked each cycle: busy=0 and normalized sel != active_sel. When it holds:
  - active_sel <= normalized sel; acc <= 0; div <= 0.
  - os_tick <= 0; baud_tick <= 0; rate_changed <= 1.
  - The increment for the new code starts on the next cycle.
- Otherwise:
  - {carry, acc} <= acc + INC[active_sel], with acc wrapping mod 2^ACC_W.
  - os_tick <= carry; rate_changed <= 0.
  - If carry: div <= div + 1 (4-bit, wraps 15->0), and baud_tick <= (div == 15). Else baud_tick <= 0.
- While busy=1, sel changes are ignored and the ticks continue at the old rate. A pending change applies on the first cycle busy=0.
- If sel toggles and then returns to active_sel while busy=1, no change and no rate_changed pulse occur.
- All outputs are registered. os_tick is asserted the cycle after the add that overflows, which gives one cycle of latency from the carry.
- There is no mid-operation state beyond acc/div. A reset at any time restarts phase from 0 at 9600.

Decomposition:
- Shared package (uart_pkg): the baud code constants BAUD_9600..BAUD_115200, the NUM_RATES=5 constant, and the function computing INC from CLK_FREQ, baud and ACC_W.
- No sub-module. The accumulator, divide-by-16 and change controller fit in one module.

Test Plan:
- Release rst with sel=0 and busy=0: the first os_tick follows the 79th clock edge. Over 1600 os_ticks, the mean period is 78.125 clk ±1. baud_tick fires on every 16th os_tick, with a mean period of 1250 clk.
- sel=4 with busy=0: rate_changed pulses once and active_sel=4. os_tick periods are 6 or 7 clk, averaging 6.51. baud_tick mean period is 104.17 clk (115200 ±0.01%).
- Hold busy=1 and change sel 0->3: active_sel stays 0 and the ticks stay at 9600. Drop busy: on the next cycle active_sel=3, rate_changed=1, and the ticks are suppressed that cycle. The mean os_tick period then becomes 13.02 clk.
- sel=6: active_sel=0 with no rate_changed pulse if it was already 0. From active_sel=2, setting sel=7 yields active_sel=0 and one rate_changed pulse.
- Assert rst mid-stream at 57600 between ticks: the next cycle has all outputs 0 and active_sel=0. After release, the first os_tick follows the 79th edge again.
- With busy held high, sel pulses 0->2->0: no rate_changed pulse, and tick timing is identical to an unperturbed 9600 run.
